// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches the multiplexed 7-segment seg/an lines, captures
// each digit once it has dwelt long enough, and converts a complete 8-digit
// frame from segment patterns to a saturated 14-bit binary value.
module seg_scan_decoder #(
   parameter int unsigned SETTLE     = 4,
   parameter int unsigned NUM_DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            seg,
   input  logic [NUM_DIGITS-1:0] an,
   output logic [13:0]           value,
   output logic                  value_valid,
   output logic                  frame_err,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

   localparam logic [7:0]  SETTLE_C = 8'(SETTLE);
   localparam logic [17:0] MAX_VAL  = 18'd16383;

   // Segment pattern decode, returns {valid, blank, digit[3:0]}
   function automatic logic [5:0] decode_seg(input logic [6:0] pat);
      logic [5:0] r;
      case (pat)
         7'h40:   r = {2'b10, 4'd0};
         7'h79:   r = {2'b10, 4'd1};
         7'h24:   r = {2'b10, 4'd2};
         7'h30:   r = {2'b10, 4'd3};
         7'h19:   r = {2'b10, 4'd4};
         7'h12:   r = {2'b10, 4'd5};
         7'h02:   r = {2'b10, 4'd6};
         7'h78:   r = {2'b10, 4'd7};
         7'h00:   r = {2'b10, 4'd8};
         7'h10:   r = {2'b10, 4'd9};
         7'h7F:   r = {2'b01, 4'd0};
         default: r = {2'b00, 4'd0};
      endcase
      return r;
   endfunction

   // Returns {exactly_one_low, index_of_low_bit} for an active-low anode word
   function automatic logic [3:0] low_index(input logic [NUM_DIGITS-1:0] a);
      logic [3:0] zeros;
      logic [2:0] idx;
      zeros = 4'd0;
      idx   = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!a[i]) begin
            zeros = zeros + 4'd1;
            idx   = 3'(i);
         end else begin
            zeros = zeros;
         end
      end
      return {(zeros == 4'd1), idx};
   endfunction

   logic [6:0]                  seg_q_r;
   logic [NUM_DIGITS-1:0]       an_q_r;
   logic [NUM_DIGITS+6:0]       prev_r;
   logic [7:0]                  cnt_r;
   logic                        captured_r;
   logic [NUM_DIGITS-1:0][6:0]  slot_r;
   logic [NUM_DIGITS-1:0][6:0]  conv_r;
   logic [NUM_DIGITS-1:0]       seen_r;
   state_t                      state_r, state_s;
   logic [16:0]                 acc_r, acc_s;
   logic                        err_r, err_s, ovf_r, ovf_s, nb_r, nb_s;
   logic [2:0]                  k_r, k_s;
   logic [13:0]                 value_r, value_s;
   logic                        valid_r, valid_s, ferr_r, ferr_s, busy_r, busy_s;

   logic [NUM_DIGITS+6:0]       sample_s;
   logic                        change_s, capture_s, snapshot_s;
   logic [3:0]                  low_s;
   logic [NUM_DIGITS-1:0]       cap_mask_s;
   logic [5:0]                  dec_s;
   logic [17:0]                 acc18_s, sum_s;

   // Compare the current registered sample with the previous one and qualify a capture
   always_comb begin
      sample_s   = {an_q_r, seg_q_r};
      change_s   = (sample_s != prev_r);
      low_s      = low_index(prev_r[NUM_DIGITS+6:7]);
      capture_s  = (cnt_r == SETTLE_C) && !captured_r && low_s[3];
      if (capture_s) begin
         cap_mask_s = NUM_DIGITS'(1) << low_s[2:0];
      end else begin
         cap_mask_s = '0;
      end
   end

   // Input sampling register
   always_ff @(posedge clk) begin
      if (reset) begin
         seg_q_r <= 7'd0;
         an_q_r  <= '0;
      end else begin
         seg_q_r <= seg;
         an_q_r  <= an;
      end
   end

   // Dwell counter: saturates at SETTLE on a stable sample, restarts on any change
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_r     <= '0;
         cnt_r      <= 8'd0;
         captured_r <= 1'b0;
      end else begin
         prev_r <= sample_s;
         if (change_s) begin
            cnt_r      <= 8'd1;
            captured_r <= 1'b0;
         end else begin
            if (cnt_r < SETTLE_C) begin
               cnt_r <= cnt_r + 8'd1;
            end
            captured_r <= captured_r | capture_s;
         end
      end
   end

   // Digit slots, seen mask and conversion snapshot; a capture in the snapshot cycle starts the next frame
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_r <= '0;
         conv_r <= '0;
         seen_r <= '0;
      end else begin
         if (capture_s) begin
            slot_r[low_s[2:0]] <= prev_r[6:0];
         end
         if (snapshot_s) begin
            conv_r <= slot_r;
            seen_r <= cap_mask_s;
         end else begin
            seen_r <= seen_r | cap_mask_s;
         end
      end
   end

   // Conversion FSM: next state, accumulator update and output values
   always_comb begin
      state_s    = state_r;
      acc_s      = acc_r;
      err_s      = err_r;
      ovf_s      = ovf_r;
      nb_s       = nb_r;
      k_s        = k_r;
      value_s    = value_r;
      valid_s    = 1'b0;
      ferr_s     = ferr_r;
      busy_s     = busy_r;
      snapshot_s = 1'b0;
      dec_s      = decode_seg(conv_r[k_r]);
      acc18_s    = {1'b0, acc_r};
      // Kept one bit wider than the accumulator so that 16383*10+9 cannot wrap
      sum_s      = (acc18_s << 3) + (acc18_s << 1) + {14'd0, dec_s[3:0]};
      case (state_r)
         IDLE: begin
            if (seen_r == '1) begin
               snapshot_s = 1'b1;
               acc_s      = 17'd0;
               err_s      = 1'b0;
               ovf_s      = 1'b0;
               nb_s       = 1'b0;
               k_s        = 3'(NUM_DIGITS - 1);
               busy_s     = 1'b1;
               state_s    = CONV;
            end else begin
               state_s = IDLE;
            end
         end
         CONV: begin
            if (dec_s[4]) begin
               // Blank: only leading blanks are legal
               if (nb_r) begin
                  err_s = 1'b1;
               end else begin
                  err_s = err_r;
               end
            end else begin
               nb_s = 1'b1;
               if (!dec_s[5]) begin
                  err_s = 1'b1;
               end else begin
                  err_s = err_r;
               end
               if (sum_s > MAX_VAL) begin
                  ovf_s = 1'b1;
                  acc_s = MAX_VAL[16:0];
               end else begin
                  acc_s = sum_s[16:0];
               end
            end
            if (k_r == 3'd0) begin
               state_s = DONE;
            end else begin
               k_s = k_r - 3'd1;
            end
         end
         DONE: begin
            value_s = acc_r[13:0];
            ferr_s  = err_r | ovf_r;
            valid_s = 1'b1;
            busy_s  = 1'b0;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         acc_r   <= 17'd0;
         err_r   <= 1'b0;
         ovf_r   <= 1'b0;
         nb_r    <= 1'b0;
         k_r     <= 3'd0;
         value_r <= 14'd0;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         acc_r   <= acc_s;
         err_r   <= err_s;
         ovf_r   <= ovf_s;
         nb_r    <= nb_s;
         k_r     <= k_s;
         value_r <= value_s;
         valid_r <= valid_s;
         ferr_r  <= ferr_s;
         busy_r  <= busy_s;
      end
   end

   assign value       = value_r;
   assign value_valid = valid_r;
   assign frame_err   = ferr_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of display frames plus hand-written
// sequences for short dwells, anode glitches and reset during conversion.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  seg;
   logic [7:0]  an;
   logic [13:0] value;
   logic        value_valid;
   logic        frame_err;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [13:0] q_val[$];
   logic        q_err[$];
   int          q_lat[$];
   int          busy_cnt = 0;
   int          dbl_cnt  = 0;
   logic        prev_v   = 1'b0;

   typedef struct {
      logic [7:0][6:0] pats;   // pats[i] = pattern of digit i
      logic [13:0]     ev;
      logic            ee;
      bit              cv;     // compare value (not meaningful on some error frames)
   } vec_t;

   vec_t vecs[10];

   seg_scan_decoder #(.SETTLE(4), .NUM_DIGITS(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .seg         (seg),
      .an          (an),
      .value       (value),
      .value_valid (value_valid),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Record every value_valid pulse with the busy duration that preceded it
   always @(negedge clk) begin
      if (reset) begin
         busy_cnt = 0;
         prev_v   = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         if (value_valid && prev_v) dbl_cnt++;
         prev_v = value_valid;
         if (value_valid) begin
            q_val.push_back(value);
            q_err.push_back(frame_err);
            q_lat.push_back(busy_cnt);
            busy_cnt = 0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic hold_digit(input int idx, input logic [6:0] p, input int n);
      an  = ~(8'h01 << idx);
      seg = p;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_an(input int n);
      an  = 8'hFF;
      seg = 7'h7F;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan_frame(input logic [7:0][6:0] pats, input int n);
      for (int i = 7; i >= 0; i--) hold_digit(i, pats[i], n);
   endtask

   task automatic expect_frame(input string name, input logic [13:0] ev, input logic ee, input bit cv);
      int t;
      logic [13:0] v;
      logic e;
      int l;
      t = 0;
      while (q_val.size() == 0 && t < 80) begin
         @(negedge clk);
         t++;
      end
      if (q_val.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_pulse required=pulse", name);
      end else begin
         v = q_val.pop_front();
         e = q_err.pop_front();
         l = q_lat.pop_front();
         if (cv) check({name, "_value"}, 32'(v), 32'(ev));
         check({name, "_err"}, 32'(e), 32'(ee));
         check({name, "_busy_cycles"}, 32'(l), 32'd9);
      end
   endtask

   task automatic expect_none(input string name, input int n);
      repeat (n) @(negedge clk);
      check(name, 32'(q_val.size()), 32'd0);
      q_val.delete();
      q_err.delete();
      q_lat.delete();
   endtask

   initial begin
      logic [7:0][6:0] p42;
      logic [7:0][6:0] p1234;
      int t;

      vecs[0] = '{{7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h24}, 14'd12,    1'b0, 1'b1};
      vecs[1] = '{{7'h40,7'h40,7'h40,7'h40,7'h10,7'h10,7'h10,7'h10}, 14'd9999,  1'b0, 1'b1};
      vecs[2] = '{{7'h40,7'h40,7'h40,7'h24,7'h40,7'h40,7'h40,7'h40}, 14'd16383, 1'b1, 1'b1};
      vecs[3] = '{{7'h7F,7'h7F,7'h7F,7'h7F,7'h7E,7'h24,7'h30,7'h19}, 14'd0,     1'b1, 1'b0};
      vecs[4] = '{{7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h24,7'h30,7'h19}, 14'd1234,  1'b0, 1'b1};
      vecs[5] = '{{7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h7F,7'h30,7'h19}, 14'd0,     1'b1, 1'b0};
      vecs[6] = '{{7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F}, 14'd0,     1'b0, 1'b1};
      vecs[7] = '{{7'h40,7'h40,7'h40,7'h79,7'h02,7'h30,7'h00,7'h30}, 14'd16383, 1'b0, 1'b1};
      vecs[8] = '{{7'h40,7'h40,7'h40,7'h79,7'h02,7'h30,7'h00,7'h19}, 14'd16383, 1'b1, 1'b1};
      vecs[9] = '{{7'h00,7'h78,7'h02,7'h12,7'h19,7'h30,7'h24,7'h79}, 14'd16383, 1'b1, 1'b1};
      p42   = {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h19,7'h24};
      p1234 = vecs[4].pats;

      reset = 1'b1;
      an    = 8'hFF;
      seg   = 7'h7F;
      repeat (3) @(negedge clk);
      check("rst_value", 32'(value), 32'd0);
      check("rst_valid", 32'(value_valid), 32'd0);
      check("rst_err",   32'(frame_err), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      reset = 1'b0;
      idle_an(5);

      // Table-driven frames, each digit held 20 cycles
      for (int i = 0; i < 10; i++) begin
         scan_frame(vecs[i].pats, 20);
         idle_an(5);
         expect_frame($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ee, vecs[i].cv);
      end

      // Short dwells (SETTLE-1), a two-low anode glitch and blank gaps must not capture
      for (int i = 7; i >= 0; i--) hold_digit(i, p1234[i], 3);
      an = 8'hFC; seg = 7'h24;
      repeat (20) @(negedge clk);
      idle_an(20);
      expect_none("short_dwell_no_pulse", 30);

      // Full frame except digit 3 dwells too briefly: still incomplete
      for (int i = 7; i >= 0; i--) begin
         hold_digit(i, p1234[i], (i == 3) ? 3 : 20);
         if (i == 5) idle_an(10);
      end
      idle_an(10);
      expect_none("missing_digit_no_pulse", 30);

      // Digit 3 alone now completes the frame from the stored slots
      hold_digit(3, p1234[3], 20);
      idle_an(5);
      expect_frame("late_digit3", 14'd1234, 1'b0, 1'b1);

      // Reset during conversion of 42 aborts without a pulse
      scan_frame(p42, 8);
      an = 8'hFF; seg = 7'h7F;
      t = 0;
      while (!busy && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("abort_busy_seen", 32'(busy), 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_value", 32'(value), 32'd0);
      check("abort_busy",  32'(busy), 32'd0);
      check("abort_err",   32'(frame_err), 32'd0);
      expect_none("abort_no_pulse", 30);
      check("abort_value_held", 32'(value), 32'd0);

      scan_frame(p42, 20);
      idle_an(5);
      expect_frame("after_abort_42", 14'd42, 1'b0, 1'b1);

      check("single_cycle_pulse", 32'(dbl_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
